// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall producer: load-use bubble, branch flush, start gating and a
// freeze for multi-cycle data-memory accesses, plus a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_useRs2_i,
  input  logic        ex_memRead_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        mem_access_i,
  input  logic        branchTaken_i,
  output logic        hazardDetected_o,
  output logic        pcWrite_o,
  output logic        ifidWrite_o,
  output logic        ifidFlush_o,
  output logic        pipeFreeze_o,
  output logic [31:0] stallCycles_o
);

  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT} state_t;

  localparam bit                MEM_WAIT_EN = (MEM_LAT > 1);
  localparam int                CNT_INIT_I  = MEM_WAIT_EN ? (MEM_LAT - 2) : 0;
  localparam logic [CNT_W-1:0]  CNT_INIT    = CNT_INIT_I[CNT_W-1:0];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      stall_q;
  logic             load_use;
  logic             mem_hold;

  assign load_use = ex_memRead_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (id_useRs2_i && (ex_rd_i == id_rs2_i)));

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    mem_hold         = 1'b0;
    pcWrite_o        = 1'b1;
    ifidWrite_o      = 1'b1;
    pipeFreeze_o     = 1'b0;
    hazardDetected_o = 1'b0;
    ifidFlush_o      = 1'b0;

    case (state)
      IDLE: begin
        pcWrite_o    = 1'b0;
        ifidWrite_o  = 1'b0;
        pipeFreeze_o = 1'b1;
        if (start_i) state_nxt = RUN;
      end
      RUN: begin
        if (MEM_WAIT_EN && mem_access_i) begin
          mem_hold  = 1'b1;
          state_nxt = MEMWAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      MEMWAIT: begin
        // The release cycle ignores mem_access_i: it still reflects the same access.
        if (cnt != '0) begin
          mem_hold = 1'b1;
          cnt_nxt  = cnt - CNT_W'(1);
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      if (mem_hold) begin
        pcWrite_o    = 1'b0;
        ifidWrite_o  = 1'b0;
        pipeFreeze_o = 1'b1;
      end else if (load_use) begin
        // Branch is suppressed here; it is re-evaluated once the bubble clears.
        hazardDetected_o = 1'b1;
        pcWrite_o        = 1'b0;
        ifidWrite_o      = 1'b0;
      end else if (branchTaken_i) begin
        ifidFlush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q <= '0;
    end else if ((state != IDLE) && !pcWrite_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stallCycles_o = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the stall rules.
module tb_hazard_stall_ctrl;
  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_i, start_i, id_useRs2_i, ex_memRead_i, mem_access_i, branchTaken_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        hazardDetected_o, pcWrite_o, ifidWrite_o, ifidFlush_o, pipeFreeze_o;
  logic [31:0] stallCycles_o;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_useRs2_i(id_useRs2_i),
    .ex_memRead_i(ex_memRead_i), .ex_rd_i(ex_rd_i), .mem_access_i(mem_access_i),
    .branchTaken_i(branchTaken_i), .hazardDetected_o(hazardDetected_o),
    .pcWrite_o(pcWrite_o), .ifidWrite_o(ifidWrite_o), .ifidFlush_o(ifidFlush_o),
    .pipeFreeze_o(pipeFreeze_o), .stallCycles_o(stallCycles_o)
  );

  int tests = 0;
  int fails = 0;

  // Model: started flag, frozen cycles still to come, pending release cycle.
  bit          m_started, n_started, m_rel, n_rel;
  int          m_frz, n_frz;
  logic [31:0] m_stall;
  logic        e_pc, e_ifid, e_frz, e_haz, e_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_started = 1'b0; m_rel = 1'b0; m_frz = 0; m_stall = '0;
  endtask

  task automatic model_eval();
    bit lu, hold;
    lu = ex_memRead_i && (ex_rd_i != 0) &&
         ((ex_rd_i == id_rs1_i) || (id_useRs2_i && (ex_rd_i == id_rs2_i)));
    hold = 1'b0;
    n_started = m_started; n_frz = m_frz; n_rel = m_rel;
    e_pc = 1'b1; e_ifid = 1'b1; e_frz = 1'b0; e_haz = 1'b0; e_fl = 1'b0;
    if (!m_started) begin
      e_pc = 1'b0; e_ifid = 1'b0; e_frz = 1'b1;
      n_started = start_i;
    end else begin
      if (m_frz > 0) begin
        hold = 1'b1; n_frz = m_frz - 1;
      end else if (m_rel) begin
        n_rel = 1'b0;
      end else if (mem_access_i && MEM_LAT > 1) begin
        hold = 1'b1; n_frz = MEM_LAT - 2; n_rel = 1'b1;
      end
      if (hold) begin
        e_pc = 1'b0; e_ifid = 1'b0; e_frz = 1'b1;
      end else if (lu) begin
        e_haz = 1'b1; e_pc = 1'b0; e_ifid = 1'b0;
      end else if (branchTaken_i) begin
        e_fl = 1'b1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pcWrite"},   32'(pcWrite_o),        32'(e_pc));
    chk({tag, ".ifidWrite"}, 32'(ifidWrite_o),      32'(e_ifid));
    chk({tag, ".freeze"},    32'(pipeFreeze_o),     32'(e_frz));
    chk({tag, ".hazard"},    32'(hazardDetected_o), 32'(e_haz));
    chk({tag, ".flush"},     32'(ifidFlush_o),      32'(e_fl));
    chk({tag, ".stalls"},    stallCycles_o,         m_stall);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1;
    model_eval();
    check_outputs(tag);
    @(posedge clk);
    if (m_started && !e_pc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    m_started = n_started; m_frz = n_frz; m_rel = n_rel;
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic ma, input logic br);
    start_i = st; id_rs1_i = rs1; id_rs2_i = rs2; id_useRs2_i = u2;
    ex_memRead_i = mr; ex_rd_i = rd; mem_access_i = ma; branchTaken_i = br;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    step("reset");
    rst_i = 1'b1;

    // Start gating
    for (int i = 0; i < 3; i++) step("idle");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("start_edge");
    step("run0");

    // Load-use on rs2, then the same with rd=x0
    drive(1, 1, 5, 1, 1, 5, 0, 0); step("lu_rs2");
    drive(1, 0, 0, 1, 1, 0, 0, 0); step("lu_rd0");

    // Load-use together with a taken branch, then the branch alone
    drive(1, 3, 0, 0, 1, 3, 0, 1); step("lu_br");
    drive(1, 3, 0, 0, 0, 3, 0, 1); step("br_after");

    // Memory access held high: freeze, freeze, release, re-trigger ...
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step("memwait");
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step("mem_drain0");
    step("mem_drain1");
    chk("stall_after_mem", stallCycles_o, m_stall);

    // Asynchronous reset during the first freeze cycle
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("pre_rst.freeze", 32'(pipeFreeze_o), 32'd1);
    rst_i = 1'b0;
    #1;
    m_reset();
    chk("async_rst.freeze",  32'(pipeFreeze_o), 32'd1);
    chk("async_rst.pcWrite", 32'(pcWrite_o),    32'd0);
    chk("async_rst.stalls",  stallCycles_o,     32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    step("restart_idle");
    for (int i = 0; i < 4; i++) step("fresh_mem");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
            1'($urandom));
      step("rand");
    end

    // Saturation of the stall counter
    drive(1, 2, 0, 0, 1, 2, 0, 0);
    force dut.stall_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_q;
    m_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 3; i++) step("sat");
    chk("sat_final", stallCycles_o, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
